// File: rtl/des_multi_core_controller.sv
// des_multi_core_controller
// Command-driven controller for an array of DES linear-cryptanalysis cores.
// It decodes mailbox commands into shared configuration registers (seed,
// polynomial, input/output masks, limit, round-key chain), per-core enables
// and a readback selector. It starts the enabled cores, waits until every
// enabled core has reported done, and captures either one core's counter or
// the 64-bit wrapped sum of the enabled cores' counters.
module des_multi_core_controller #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 48,
  parameter int NUM_KEYS  = 16,
  parameter int KEY_W     = 48
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   cmd,
  input  logic                          cmd_valid,
  input  logic [31:0]                   data_upper,
  input  logic [31:0]                   data_lower,
  output logic                          cmd_read,
  output logic                          done,
  output logic [63:0]                   counter,
  output logic [NUM_CORES-1:0]          core_start,
  output logic                          core_restart,
  output logic [64*NUM_CORES-1:0]       seed_o,
  output logic [63:0]                   poly_o,
  output logic [63:0]                   mask_i_o,
  output logic [63:0]                   mask_o_o,
  output logic [63:0]                   limit_o,
  output logic [NUM_KEYS*KEY_W-1:0]     round_keys_o,
  input  logic [CNT_W*NUM_CORES-1:0]    core_counter_i,
  input  logic [NUM_CORES-1:0]          core_done_i
);

  localparam logic [7:0] OP_SEED    = 8'd1;
  localparam logic [7:0] OP_POLY    = 8'd2;
  localparam logic [7:0] OP_IMASK   = 8'd3;
  localparam logic [7:0] OP_OMASK   = 8'd4;
  localparam logic [7:0] OP_LIMIT   = 8'd5;
  localparam logic [7:0] OP_KEY     = 8'd6;
  localparam logic [7:0] OP_START   = 8'd7;
  localparam logic [7:0] OP_RESTART = 8'd8;
  localparam logic [7:0] OP_ENABLE  = 8'd9;
  localparam logic [7:0] OP_SELECT  = 8'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACK,
    S_ACK_START,
    S_START,
    S_RUN,
    S_FINISH,
    S_RESTART
  } state_t;

  state_t state, state_next;

  logic sync_q1;
  logic vsync;

  logic [63:0] seed_r;
  logic [63:0] poly_r;
  logic [63:0] mask_i_r;
  logic [63:0] mask_o_r;
  logic [63:0] limit_r;
  logic [KEY_W-1:0] key_r [NUM_KEYS];
  logic [NUM_CORES-1:0] enable_r;
  logic [7:0] select_r;

  logic [NUM_CORES-1:0] done_seen_r;
  logic [63:0] counter_r;

  logic [7:0]  opcode;
  logic [63:0] cmd_data;
  logic        restart_req;
  logic        all_done;
  logic [63:0] sum_val;
  logic [63:0] sel_val;
  logic [63:0] counter_next;
  logic        unused_cmd_bits;

  assign opcode          = cmd[7:0];
  assign cmd_data        = {data_upper, data_lower};
  assign restart_req     = vsync && (opcode == OP_RESTART);
  assign all_done        = &(done_seen_r | core_done_i | ~enable_r);
  assign unused_cmd_bits = ^cmd[31:16];

  // Two-flop synchroniser: cmd_valid comes from another clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      vsync   <= 1'b0;
    end else begin
      sync_q1 <= cmd_valid;
      vsync   <= sync_q1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake/core-control outputs; restart beats finish detection.
  always_comb begin
    state_next   = state;
    cmd_read     = 1'b0;
    core_start   = '0;
    core_restart = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (vsync) begin
          if (opcode == OP_START) begin
            state_next = S_ACK_START;
          end else if (opcode == OP_RESTART) begin
            state_next = S_RESTART;
          end else begin
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        state_next = S_ACK;
      end
      S_ACK: begin
        cmd_read = 1'b1;
        if (!vsync) begin
          state_next = S_IDLE;
        end
      end
      S_ACK_START: begin
        cmd_read = 1'b1;
        if (!vsync) begin
          state_next = S_START;
        end
      end
      S_START: begin
        core_start = enable_r;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (restart_req) begin
          state_next = S_RESTART;
        end else if (all_done) begin
          state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        done = 1'b1;
        if (restart_req) begin
          state_next = S_RESTART;
        end
      end
      S_RESTART: begin
        cmd_read     = 1'b1;
        core_restart = 1'b1;
        if (!vsync) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Configuration writes happen exactly once, in the single LOAD cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seed_r   <= '0;
      poly_r   <= '0;
      mask_i_r <= '0;
      mask_o_r <= '0;
      limit_r  <= '0;
      enable_r <= '1;
      select_r <= 8'hFF;
      for (int i = 0; i < NUM_KEYS; i++) begin
        key_r[i] <= '0;
      end
    end else if (state == S_LOAD) begin
      case (opcode)
        OP_SEED:   seed_r   <= cmd_data;
        OP_POLY:   poly_r   <= cmd_data;
        OP_IMASK:  mask_i_r <= cmd_data;
        OP_OMASK:  mask_o_r <= cmd_data;
        OP_LIMIT:  limit_r  <= cmd_data;
        OP_KEY: begin
          for (int i = 0; i < NUM_KEYS - 1; i++) begin
            key_r[i] <= key_r[i+1];
          end
          key_r[NUM_KEYS-1] <= KEY_W'(cmd_data);
        end
        OP_ENABLE: enable_r <= NUM_CORES'(data_lower);
        OP_SELECT: select_r <= cmd[15:8];
        default: ;
      endcase
    end
  end

  // Readback value: one core's counter if the selector names a core, else the enabled-core sum.
  always_comb begin
    sum_val = '0;
    sel_val = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (enable_r[i]) begin
        sum_val = sum_val + 64'(core_counter_i[CNT_W*i +: CNT_W]);
      end
      if (select_r == 8'(i)) begin
        sel_val = 64'(core_counter_i[CNT_W*i +: CNT_W]);
      end
    end
    counter_next = ({1'b0, select_r} < 9'(NUM_CORES)) ? sel_val : sum_val;
  end

  // Sticky per-core done tracking and counter capture on the finishing edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_seen_r <= '0;
      counter_r   <= '0;
    end else begin
      case (state)
        S_START: begin
          done_seen_r <= '0;
        end
        S_RUN: begin
          done_seen_r <= done_seen_r | core_done_i;
          if (!restart_req && all_done) begin
            counter_r <= counter_next;
          end
        end
        S_RESTART: begin
          counter_r <= '0;
        end
        default: ;
      endcase
    end
  end

  assign counter  = counter_r;
  assign poly_o   = poly_r;
  assign mask_i_o = mask_i_r;
  assign mask_o_o = mask_o_r;
  assign limit_o  = limit_r;

  // Each core gets its own seed offset so the cores search disjoint ranges.
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_seed
    assign seed_o[64*g +: 64] = seed_r + 64'(g);
  end

  // Key1 sits in the most significant slot of the flattened key bus.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_keys
    assign round_keys_o[(NUM_KEYS-1-g)*KEY_W +: KEY_W] = key_r[g];
  end

endmodule

// File: doc/des_multi_core_controller.md
Name: des_multi_core_controller

Overview:
- Command-driven controller that configures and runs NUM_CORES parallel DES linear-cryptanalysis cores from the CPU command/data port.
- Sits between the CPU mailbox (cmd, cmd_valid, data_upper/lower, cmd_read, done, counter) and an array of des_block-style cores. It drives their shared configuration and per-core seeds, and collects their counters.
- Extends the single-core wrapper in four ways:
  - core count and counter width are parameters;
  - the output mask is routed separately from the input mask;
  - cores can be enabled individually;
  - counter readback can be per core or summed.

Parameters:
NUM_CORES, 4, number of attached cores (1..255)
CNT_W, 48, width of each core counter (1..64)
NUM_KEYS, 16, number of round keys in the key shift chain
KEY_W, 48, width of each round key (KEY_W <= 64)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd  in  32  command; [7:0] opcode, [15:8] argument
cmd_valid  in  1  command valid, asynchronous to clk (2-flop synchronised internally)
data_upper  in  32  command data [63:32]
data_lower  in  32  command data [31:0]
cmd_read  out  1  command accepted; held until synchronised cmd_valid drops
done  out  1  all enabled cores finished; counter valid
counter  out  64  selected/summed result, zero-extended
core_start  out  NUM_CORES  one-cycle start pulse per enabled core
core_restart  out  1  restart to all cores
seed_o  out  64*NUM_CORES  per-core seed; core i at [64*i+:64]
poly_o  out  64  shared polynomial
mask_i_o  out  64  shared input mask
mask_o_o  out  64  shared output mask
limit_o  out  64  shared counter limit
round_keys_o  out  NUM_KEYS*KEY_W  key1 in the MSBs
core_counter_i  in  CNT_W*NUM_CORES  core i counter at [CNT_W*i+:CNT_W]
core_done_i  in  NUM_CORES  core finished flags

Behaviour:

Reset values (applied on any clk edge with rst_n=0, including mid-run):
- Outputs: cmd_read=0, done=0, counter=0, core_start=0, core_restart=0.
- Internal state:
  - seed, poly, masks, limit and all keys = 0;
  - enable mask = all ones;
  - select = 8'hFF;
  - sync flops = 0;
  - state = IDLE.

Sync:
- cmd_valid passes through 2 flops to produce vsync. The FSM uses only vsync.
- cmd and data are assumed stable while cmd_valid is high.

Opcodes:
- 1 SEED, 2 POLY, 3 IMASK, 4 OMASK, 5 LIMIT: load {data_upper,data_lower}.
- 6 KEY: shift the key chain by one. The new key {data_upper,data_lower}[KEY_W-1:0] enters the key-N slot; key1 receives key2. The first key written ends up as key1 after NUM_KEYS writes.
- 7 START.
- 8 RESTART.
- 9 ENABLE: enable mask <= data_lower[NUM_CORES-1:0].
- 10 SELECT: select <= cmd[15:8].
- Any other opcode: acknowledged, no effect.

FSM:
- IDLE:
  - vsync=1 and opcode is 1-6, 9, 10 or unknown -> LOAD.
  - vsync=1 and opcode 7 -> ACK_START.
  - vsync=1 and opcode 8 -> RESTART.
- LOAD: exactly one cycle; performs the register write once -> ACK.
- ACK: cmd_read=1; vsync=0 -> IDLE.
- ACK_START: cmd_read=1; vsync=0 -> START.
- START:
  - core_start = enable mask for one cycle;
  - clear done_seen -> RUN.
- RUN:
  - done_seen[i] |= core_done_i[i] each cycle (sticky).
  - When (done_seen | core_done_i | ~enable) is all ones -> FINISH.
  - The counter register is captured on the same edge.
- FINISH: done=1; stays until RESTART.
- RESTART: cmd_read=1, core_restart=1; vsync=0 -> IDLE; clears done and counter.

Command handling during RUN/FINISH:
- Only opcode 8 (with vsync=1) is honoured -> RESTART, with priority over finish detection.
- All other commands are not acknowledged and are held pending. They are decoded in IDLE after RESTART if cmd_valid is still high.

Latency:
- First edge sampling cmd_valid=1 is edge 1. vsync=1 after edge 2, LOAD after edge 3, cmd_read=1 after edge 4.
- cmd_read falls 3 edges after cmd_valid falls.

Seeds:
- seed_o core i = seed + i, modulo 2^64.

Counter:
- Captured value, zero-extended to 64 bits:
  - select < NUM_CORES: core_counter_i of the selected core;
  - otherwise: sum over enabled cores, computed at 64 bits with wrap modulo 2^64.
- select >= NUM_CORES and not 8'hFF: treated as sum.

Edge cases:
- START with enable mask 0: passes through RUN for one cycle -> FINISH with counter 0.
- SELECT or ENABLE issued after FINISH: takes effect on the next run only.
- Configuration registers survive RESTART.

Test Plan:
- Reset, then SEED 0x0123456789ABCDEF with NUM_CORES=4 -> cmd_read high after 4th edge; seed_o core3 = 0x0123456789ABCDF2; cmd_read low 3 edges after cmd_valid drops.
- 16 KEY writes of values 1..16 -> round_keys_o key1=1, key16=16; a 17th write of 17 gives key1=2, key16=17.
- ENABLE 0b0101, START; cores 0 and 2 assert done with counters 10 and 32 at different cycles -> core_start=0b0101 pulsed one cycle; done=1, counter=42.
- SELECT 2, START; core 2 counter = 2^CNT_W-1 -> counter = 2^CNT_W-1 zero-extended.
- RESTART issued mid-RUN -> core_restart=1 and cmd_read=1 until vsync drops, done=0, counter=0; a subsequent POLY write is accepted normally.
- Opcode 0x3F from IDLE -> acknowledged, no register changes; rst_n=0 during RUN -> all outputs at reset values next edge.
